// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD display datapath: converter FSM states and
// operand/result sizing used by the binary-to-BCD block.
package lcd_pkg;

  localparam int unsigned BIN_W      = 8;
  localparam int unsigned BCD_DIGITS = 3;
  localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
  localparam int unsigned CNT_W      = $clog2(BIN_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : lcd_pkg

// File: rtl/bcd_adj_module.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decade.
module bcd_adj_module (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Inputs reaching this block are at most 9, so din + 3 never wraps 4 bits.
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule : bcd_adj_module

// File: rtl/bin2bcd_module.sv
// Sequential 8-bit binary to 3-digit BCD converter, one bit per clock
// (shift-and-add-3). Results are registered and held until the next completion.
module bin2bcd_module
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  state_t             state_q;
  logic [BIN_W-1:0]   shift_q;
  logic [BCD_W-1:0]   scratch_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_nxt;
  logic               unused_msb;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_adj_module u_adj (
      .din  (scratch_q[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  // Corrected digits shifted left one place, taking in the next binary MSB.
  assign scratch_nxt = {scratch_adj[BCD_W-2:0], shift_q[BIN_W-1]};

  // The hundreds digit of an 8-bit value never exceeds 2, so the bit shifted
  // out of the top of the scratch register is always zero.
  assign unused_msb  = scratch_adj[BCD_W-1];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= CONV;
          end
        end

        CONV: begin
          scratch_q <= scratch_nxt;
          shift_q   <= {shift_q[BIN_W-2:0], 1'b0};
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            hundreds <= scratch_nxt[11:8];
            tens     <= scratch_nxt[7:4];
            ones     <= scratch_nxt[3:0];
            busy     <= 1'b0;
            done     <= 1'b1;
            state_q  <= DONE;
          end
        end

        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : bin2bcd_module

// File: tb/tb_bin2bcd_module.sv
// Self-checking bench for bin2bcd_module: table vectors, corner sequences and a
// full 0..255 sweep, with results matched against a scoreboard queue on done.
module tb_bin2bcd_module;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] bin;
  logic       busy;
  logic       done;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;

  typedef struct {
    int h;
    int t;
    int o;
  } exp_t;

  typedef struct {
    logic [7:0] bin;
    int         h;
    int         t;
    int         o;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  bin2bcd_module dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=%0d%0d%0d expected=none",
                 hundreds, tens, ones);
      end else begin
        e = exp_q.pop_front();
        check("hundreds", int'(hundreds), e.h);
        check("tens",     int'(tens),     e.t);
        check("ones",     int'(ones),     e.o);
      end
    end
  end

  // Called at a negedge: request conversion of v, returns at the negedge after
  // the accepting edge with bin scrambled to prove it was captured.
  task automatic launch(input logic [7:0] v, input int h, input int t, input int o);
    exp_t e;
    e.h = h;
    e.t = t;
    e.o = o;
    exp_q.push_back(e);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
  endtask

  // Waits (bounded) for done; lat counts edges after the accepting edge.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d cycles expected=done", lat);
      exp_q.delete();
    end
  endtask

  task automatic run_one(input logic [7:0] v, input int h, input int t, input int o,
                         output int lat, output int busy_cycles);
    launch(v, h, t, o);
    wait_done(lat, busy_cycles);
    @(negedge clk);
    check("done_single_cycle", int'(done), 0);
  endtask

  initial begin
    int lat;
    int bc;
    int dc;

    vecs[0] = '{8'd0,   0, 0, 0};
    vecs[1] = '{8'd255, 2, 5, 5};
    vecs[2] = '{8'd100, 1, 0, 0};
    vecs[3] = '{8'd99,  0, 9, 9};
    vecs[4] = '{8'd128, 1, 2, 8};

    rst_n = 1'b0;
    start = 1'b0;
    bin   = 8'd0;
    #1;
    check("reset_busy",  int'(busy), 0);
    check("reset_done",  int'(done), 0);
    check("reset_digits", int'({hundreds, tens, ones}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, including latency and busy duration for each.
    foreach (vecs[i]) begin
      run_one(vecs[i].bin, vecs[i].h, vecs[i].t, vecs[i].o, lat, bc);
      check("latency", lat, 8);
      check("busy_cycles", bc, 8);
    end

    // Start during CONV is dropped: one done, result of the first request.
    dc = done_count;
    launch(8'd37, 0, 3, 7);
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd200;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    repeat (15) @(negedge clk);
    check("drop_done_count", done_count - dc, 1);
    check("drop_queue_empty", exp_q.size(), 0);

    // Start held high: one conversion every 10 cycles, outputs stable between.
    begin
      int seen     = 0;
      int last     = 0;
      int unstable = 0;
      exp_t e;
      e.h = 0;
      e.t = 5;
      e.o = 6;
      repeat (3) exp_q.push_back(e);
      start = 1'b1;
      bin   = 8'd56;
      for (int t = 0; t < 60 && seen < 3; t++) begin
        @(negedge clk);
        if (done) begin
          if (seen > 0) check("b2b_period", t - last, 10);
          last = t;
          seen++;
        end else if (seen > 0 && {hundreds, tens, ones} != 12'h056) begin
          unstable++;
        end
      end
      start = 1'b0;
      check("b2b_count", seen, 3);
      check("b2b_stable", unstable, 0);
      repeat (3) @(negedge clk);
    end

    // Reset mid-conversion: immediate clear, no done, then a clean restart.
    run_one(8'd255, 2, 5, 5, lat, bc);
    dc    = done_count;
    start = 1'b1;
    bin   = 8'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_held", int'({hundreds, tens, ones}), int'(12'h255));
    rst_n = 1'b0;
    #1;
    check("abort_busy",   int'(busy), 0);
    check("abort_digits", int'({hundreds, tens, ones}), 0);
    repeat (2) @(negedge clk);
    check("abort_no_done", done_count - dc, 0);
    rst_n = 1'b1;
    launch(8'd13, 0, 1, 3);
    check("restart_busy", int'(busy), 1);
    wait_done(lat, bc);
    check("restart_latency", lat, 8);
    @(negedge clk);

    // Exhaustive sweep against divide/modulo reference.
    for (int v = 0; v < 256; v++) begin
      run_one(8'(v), v / 100, (v / 10) % 10, v % 10, lat, bc);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bin2bcd_module

// File: doc/bin2bcd_module.md
BIN2BCD_MODULE -- requirements
Module: bin2bcd_module

Interface
REQ-001 SHALL have no parameters; operand width fixed at 8 bits, result fixed at 3 BCD digits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to convert bin; sampled on rising clk.
REQ-005 SHALL have port: bin  input  8  unsigned binary value (product from the 8-bit multiplier); captured when start is accepted.
REQ-006 SHALL have port: busy  output  1  high while a conversion is in progress.
REQ-007 SHALL have port: done  output  1  single-cycle pulse; result ports valid.
REQ-008 SHALL have port: hundreds  output  4  BCD hundreds digit (0-2).
REQ-009 SHALL have port: tens  output  4  BCD tens digit (0-9).
REQ-010 SHALL have port: ones  output  4  BCD ones digit (0-9).

Function
REQ-011 SHALL implement a sequential shift-and-add-3 (double-dabble) conversion, one bit per clock.
REQ-012 SHALL use FSM states IDLE, CONV, DONE.
REQ-013 IDLE: start=1 at a rising edge -> capture bin into an 8-bit shift register, clear the 12-bit BCD scratch register and the 3-bit bit counter, go to CONV.
REQ-014 CONV, each edge: every scratch digit >= 5 gets +3 (4-bit wrap impossible), then {scratch, shift} shift left by 1, counter +1.
REQ-015 CONV: on the edge performing the 8th shift (counter = 7), load hundreds/tens/ones from the post-shift scratch value and go to DONE.
REQ-016 DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-017 Latency: start accepted at edge 0 -> results updated and done high after edge 8; busy high after edges 0..7 (CONV only).
REQ-018 start SHALL be ignored in CONV and DONE; no queuing; bin changes after acceptance SHALL not affect the result.
REQ-019 hundreds/tens/ones SHALL hold the last completed result until the next completion; never show intermediate scratch values.
REQ-020 Back-to-back: start held high continuously SHALL yield one conversion every 10 cycles (accepted on the edge after DONE -> IDLE).
REQ-021 Input 0 and 255 SHALL convert correctly (000, 255); hundreds never exceeds 2.

Reset
REQ-022 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, hundreds=tens=ones=0, counter, shift and scratch registers to 0, independent of clk.
REQ-023 Reset mid-CONV SHALL abort the conversion without a done pulse; after release, the block accepts a new start on the first edge.
REQ-024 Reset release SHALL be taken as synchronised upstream; no internal synchroniser.

Structure
REQ-025 State enum (IDLE, CONV, DONE) and constants BIN_W=8, BCD_DIGITS=3 SHALL live in the shared package lcd_pkg.
REQ-026 Per-digit correction (4-bit in, >=5 ? +3 : pass) SHALL be the combinational sub-module bcd_adj_module, instantiated once per digit.
REQ-027 All outputs SHALL be registered; no combinational path from start or bin to any output.

Verification
REQ-028 bin=8'd0, start pulse -> done after 8 edges, digits 0/0/0, busy high exactly 8 cycles.
REQ-029 bin=8'd255 -> 2/5/5; bin=8'd100 -> 1/0/0; bin=8'd99 -> 0/9/9; bin=8'd128 -> 1/2/8.
REQ-030 Start bin=37, then start with bin=200 during CONV -> single done, result 0/3/7, second request dropped.
REQ-031 Start held high with bin=56 -> done pulses every 10 cycles, each result 0/5/6, outputs stable between pulses.
REQ-032 Result 2/5/5 held; start bin=13, assert rst_n low at the 4th CONV cycle -> outputs 0/0/0 immediately, no done; after release, bin=13 converts to 0/1/3.
REQ-033 Exhaustive sweep 0..255 versus reference divide/modulo -> all 256 results match.
